// File: rtl/if_pkg.sv
// Shared constants for the instruction-fetch stage: default bubble instruction,
// fetch FSM state encoding and the register-field positions exported to the hazard unit.
package if_pkg;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h00000013;

  localparam logic [1:0] S_REQ   = 2'd0;
  localparam logic [1:0] S_HOLD  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Control priority is bubble > hold > load; a bubble
// replaces the instruction with NOP and clears valid but keeps the recorded PC.
module if_id_reg
  import if_pkg::*;
#(
  parameter int          XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            bubble,
  input  logic            hold,
  input  logic [XLEN-1:0] pc_in,
  input  logic [31:0]     instr_in,
  output logic [XLEN-1:0] ifid_pc,
  output logic [31:0]     ifid_instr,
  output logic            ifid_valid
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ifid_pc    <= '0;
      ifid_instr <= NOP_INSTR;
      ifid_valid <= 1'b0;
    end else if (bubble) begin
      ifid_instr <= NOP_INSTR;
      ifid_valid <= 1'b0;
    end else if (hold) begin
      ifid_valid <= ifid_valid;
    end else if (load) begin
      ifid_pc    <= pc_in;
      ifid_instr <= instr_in;
      ifid_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage with variable-latency req/ack memory and IF/ID register.
// Optional macro IF_PERF_CNT_EN adds saturating stall_cycles/flush_count outputs.
module if_stage
  import if_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            hold_pc,
  input  logic            hold_ifid,
  input  logic            flush,
  input  logic [XLEN-1:0] branch_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] IFIDPC,
  output logic [31:0]     IFIDInstr,
  output logic            IFIDValid,
  output logic [4:0]      IFIDRs1,
  output logic [4:0]      IFIDRs2
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]     stall_cycles,
  output logic [31:0]     flush_count
`endif
);

  logic [1:0]      state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] redirect_pc;
  logic [31:0]     skid_buf;
  logic            stall;
  logic            ifid_load;
  logic            ifid_bubble;
  logic [31:0]     ifid_instr_in;

  assign stall = hold_pc | hold_ifid;

  // The request is gated by reset so an in-flight fetch is dropped immediately;
  // during a drain the address stays on the old pc until the memory acks.
  assign imem_req  = reset & (state != S_HOLD);
  assign imem_addr = pc;

  assign ifid_bubble   = flush
                       | (state == S_DRAIN)
                       | ((state == S_REQ) & ~imem_ack & ~stall);
  assign ifid_load     = ((state == S_REQ) & imem_ack) | (state == S_HOLD);
  assign ifid_instr_in = (state == S_HOLD) ? skid_buf : imem_rdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_REQ;
      pc          <= RESET_PC;
      redirect_pc <= RESET_PC;
      skid_buf    <= NOP_INSTR;
    end else begin
      case (state)
        S_REQ: begin
          if (imem_ack) begin
            if (flush) begin
              pc <= branch_target;
            end else if (!stall) begin
              pc <= pc + XLEN'(4);
            end else begin
              skid_buf <= imem_rdata;
              state    <= S_HOLD;
            end
          end else if (flush) begin
            redirect_pc <= branch_target;
            state       <= S_DRAIN;
          end
        end
        S_HOLD: begin
          if (flush) begin
            pc    <= branch_target;
            state <= S_REQ;
          end else if (!stall) begin
            pc    <= pc + XLEN'(4);
            state <= S_REQ;
          end
        end
        S_DRAIN: begin
          // A flush coinciding with the ack is the newest redirect, so it wins.
          if (imem_ack) begin
            pc    <= flush ? branch_target : redirect_pc;
            state <= S_REQ;
          end else if (flush) begin
            redirect_pc <= branch_target;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

  if_id_reg #(
    .XLEN      (XLEN),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk        (clk),
    .reset      (reset),
    .load       (ifid_load),
    .bubble     (ifid_bubble),
    .hold       (stall),
    .pc_in      (pc),
    .instr_in   (ifid_instr_in),
    .ifid_pc    (IFIDPC),
    .ifid_instr (IFIDInstr),
    .ifid_valid (IFIDValid)
  );

  assign IFIDRs1 = IFIDInstr[RS1_LSB +: 5];
  assign IFIDRs2 = IFIDInstr[RS2_LSB +: 5];

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall && !flush && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
      if (flush && flush_count != '1) flush_count <= flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage: reset, streaming fetch, stall/skid,
// flush with drain, flush-over-hold, bubble insertion, mid-wait reset and PC wrap.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] I0  = 32'h00500093;
  localparam logic [31:0] I1  = 32'h002081B3;
  localparam logic [31:0] I2  = 32'h00418233;
  localparam logic [31:0] JNK = 32'hFFFFFFFF;

  logic        clk = 1'b0;
  logic        reset;
  logic        hold_pc, hold_ifid, flush, imem_ack;
  logic [31:0] branch_target, imem_rdata;
  logic        imem_req, IFIDValid;
  logic [31:0] imem_addr, IFIDPC, IFIDInstr;
  logic [4:0]  IFIDRs1, IFIDRs2;

  logic        w_reset, w_req, w_valid;
  logic [31:0] w_addr, w_pc, w_instr;
  logic [4:0]  w_rs1, w_rs2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  if_stage dut (
    .clk(clk), .reset(reset), .hold_pc(hold_pc), .hold_ifid(hold_ifid),
    .flush(flush), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .IFIDPC(IFIDPC), .IFIDInstr(IFIDInstr), .IFIDValid(IFIDValid),
    .IFIDRs1(IFIDRs1), .IFIDRs2(IFIDRs2)
  );

  if_stage #(.RESET_PC(32'hFFFFFFFC)) u_wrap (
    .clk(clk), .reset(w_reset), .hold_pc(1'b0), .hold_ifid(1'b0),
    .flush(1'b0), .branch_target(32'h0),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ack(1'b1), .imem_rdata(I0),
    .IFIDPC(w_pc), .IFIDInstr(w_instr), .IFIDValid(w_valid),
    .IFIDRs1(w_rs1), .IFIDRs2(w_rs2)
  );

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL rst_req: got %b expected 0", imem_req); end
    checks++; if (IFIDPC !== 32'h0) begin errors++; $display("[TB] FAIL rst_pc: got %h expected 0", IFIDPC); end
    checks++; if (IFIDInstr !== NOP) begin errors++; $display("[TB] FAIL rst_instr: got %h expected %h", IFIDInstr, NOP); end
    checks++; if (IFIDValid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid: got %b expected 0", IFIDValid); end
    checks++; if (IFIDRs1 !== 5'd0 || IFIDRs2 !== 5'd0) begin errors++; $display("[TB] FAIL rst_rs: got %0d/%0d expected 0/0", IFIDRs1, IFIDRs2); end
    reset = 1'b1;
    imem_ack = 1'b1;
    imem_rdata = I0;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL rel_req: got %b/%h expected 1/0", imem_req, imem_addr); end
  endtask

  task automatic test_stream();
    @(posedge clk); #1;
    checks++; if (IFIDPC !== 32'h0 || IFIDInstr !== I0 || IFIDValid !== 1'b1) begin errors++; $display("[TB] FAIL stream0: got %h/%h/%b expected 0/%h/1", IFIDPC, IFIDInstr, IFIDValid, I0); end
    checks++; if (IFIDRs1 !== 5'd0 || IFIDRs2 !== 5'd5) begin errors++; $display("[TB] FAIL stream0_rs: got %0d/%0d expected 0/5", IFIDRs1, IFIDRs2); end
    checks++; if (imem_addr !== 32'h4) begin errors++; $display("[TB] FAIL stream0_addr: got %h expected 4", imem_addr); end
    imem_rdata = I1;
    @(posedge clk); #1;
    checks++; if (IFIDPC !== 32'h4 || IFIDInstr !== I1 || IFIDValid !== 1'b1) begin errors++; $display("[TB] FAIL stream1: got %h/%h/%b expected 4/%h/1", IFIDPC, IFIDInstr, IFIDValid, I1); end
    checks++; if (IFIDRs1 !== 5'd1 || IFIDRs2 !== 5'd2) begin errors++; $display("[TB] FAIL stream1_rs: got %0d/%0d expected 1/2", IFIDRs1, IFIDRs2); end
    checks++; if (imem_addr !== 32'h8) begin errors++; $display("[TB] FAIL stream1_addr: got %h expected 8", imem_addr); end
  endtask

  task automatic test_stall();
    hold_pc = 1'b1; hold_ifid = 1'b1; imem_rdata = I2;
    @(posedge clk); #1;
    checks++; if (IFIDPC !== 32'h4 || IFIDInstr !== I1) begin errors++; $display("[TB] FAIL stall1_ifid: got %h/%h expected 4/%h", IFIDPC, IFIDInstr, I1); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL stall1_req: got %b expected 0", imem_req); end
    imem_ack = 1'b0; imem_rdata = JNK;
    @(posedge clk); #1;
    checks++; if (IFIDPC !== 32'h4 || IFIDValid !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("[TB] FAIL stall2: got %h/%b/%b expected 4/1/0", IFIDPC, IFIDValid, imem_req); end
    hold_pc = 1'b0; hold_ifid = 1'b0;
    @(posedge clk); #1;
    checks++; if (IFIDPC !== 32'h8 || IFIDInstr !== I2 || IFIDValid !== 1'b1) begin errors++; $display("[TB] FAIL unstall: got %h/%h/%b expected 8/%h/1", IFIDPC, IFIDInstr, IFIDValid, I2); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin errors++; $display("[TB] FAIL unstall_addr: got %b/%h expected 1/c", imem_req, imem_addr); end
  endtask

  task automatic test_flush_drain();
    flush = 1'b1; branch_target = 32'h40; imem_ack = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0; branch_target = 32'h0;
    checks++; if (IFIDValid !== 1'b0 || IFIDInstr !== NOP || IFIDPC !== 32'h8) begin errors++; $display("[TB] FAIL flush_bubble: got %b/%h/%h expected 0/%h/8", IFIDValid, IFIDInstr, IFIDPC, NOP); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin errors++; $display("[TB] FAIL drain0_addr: got %b/%h expected 1/c", imem_req, imem_addr); end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++; if (imem_addr !== 32'hC || imem_req !== 1'b1 || IFIDValid !== 1'b0) begin errors++; $display("[TB] FAIL drain_wait%0d: got %h/%b/%b expected c/1/0", i, imem_addr, imem_req, IFIDValid); end
    end
    imem_ack = 1'b1; imem_rdata = JNK;
    @(posedge clk); #1;
    checks++; if (IFIDValid !== 1'b0 || IFIDInstr !== NOP) begin errors++; $display("[TB] FAIL drain_discard: got %b/%h expected 0/%h", IFIDValid, IFIDInstr, NOP); end
    checks++; if (imem_addr !== 32'h40 || imem_req !== 1'b1) begin errors++; $display("[TB] FAIL redirect_addr: got %h/%b expected 40/1", imem_addr, imem_req); end
    imem_rdata = I1;
    @(posedge clk); #1;
    checks++; if (IFIDPC !== 32'h40 || IFIDInstr !== I1 || IFIDValid !== 1'b1) begin errors++; $display("[TB] FAIL target_fetch: got %h/%h/%b expected 40/%h/1", IFIDPC, IFIDInstr, IFIDValid, I1); end
  endtask

  task automatic test_flush_hold();
    flush = 1'b1; hold_pc = 1'b1; hold_ifid = 1'b1; branch_target = 32'h80; imem_rdata = I2;
    @(posedge clk); #1;
    flush = 1'b0; hold_pc = 1'b0; hold_ifid = 1'b0;
    checks++; if (IFIDValid !== 1'b0 || IFIDInstr !== NOP) begin errors++; $display("[TB] FAIL fh_bubble: got %b/%h expected 0/%h", IFIDValid, IFIDInstr, NOP); end
    checks++; if (IFIDRs1 !== 5'd0 || IFIDRs2 !== 5'd0) begin errors++; $display("[TB] FAIL fh_rs: got %0d/%0d expected 0/0", IFIDRs1, IFIDRs2); end
    checks++; if (imem_addr !== 32'h80 || imem_req !== 1'b1) begin errors++; $display("[TB] FAIL fh_addr: got %h/%b expected 80/1", imem_addr, imem_req); end
  endtask

  task automatic test_bubble();
    imem_ack = 1'b0;
    @(posedge clk); #1;
    checks++; if (IFIDValid !== 1'b0 || IFIDPC !== 32'h40 || imem_addr !== 32'h80) begin errors++; $display("[TB] FAIL wait_bubble: got %b/%h/%h expected 0/40/80", IFIDValid, IFIDPC, imem_addr); end
    imem_ack = 1'b1; imem_rdata = I0;
    @(posedge clk); #1;
    checks++; if (IFIDPC !== 32'h80 || IFIDInstr !== I0 || IFIDValid !== 1'b1) begin errors++; $display("[TB] FAIL late_ack: got %h/%h/%b expected 80/%h/1", IFIDPC, IFIDInstr, IFIDValid, I0); end
  endtask

  task automatic test_reset_midwait();
    imem_ack = 1'b0;
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_req: got %b expected 0", imem_req); end
    checks++; if (IFIDValid !== 1'b0 || IFIDPC !== 32'h0 || IFIDInstr !== NOP) begin errors++; $display("[TB] FAIL mid_rst_ifid: got %b/%h/%h expected 0/0/%h", IFIDValid, IFIDPC, IFIDInstr, NOP); end
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL mid_rel: got %b/%h expected 1/0", imem_req, imem_addr); end
    imem_ack = 1'b1; imem_rdata = I2;
    @(posedge clk); #1;
    checks++; if (IFIDPC !== 32'h0 || IFIDInstr !== I2 || IFIDValid !== 1'b1) begin errors++; $display("[TB] FAIL mid_refetch: got %h/%h/%b expected 0/%h/1", IFIDPC, IFIDInstr, IFIDValid, I2); end
  endtask

  task automatic test_wrap();
    w_reset = 1'b1;
    #1;
    checks++; if (w_addr !== 32'hFFFFFFFC || w_req !== 1'b1) begin errors++; $display("[TB] FAIL wrap_first: got %h/%b expected fffffffc/1", w_addr, w_req); end
    @(posedge clk); #1;
    checks++; if (w_pc !== 32'hFFFFFFFC || w_valid !== 1'b1 || w_instr !== I0) begin errors++; $display("[TB] FAIL wrap_ifid: got %h/%b/%h expected fffffffc/1/%h", w_pc, w_valid, w_instr, I0); end
    checks++; if (w_addr !== 32'h0) begin errors++; $display("[TB] FAIL wrap_addr: got %h expected 0", w_addr); end
  endtask

  initial begin
    reset = 1'b0; w_reset = 1'b0;
    hold_pc = 1'b0; hold_ifid = 1'b0; flush = 1'b0;
    branch_target = 32'h0; imem_ack = 1'b0; imem_rdata = 32'h0;
    test_reset();
    test_stream();
    test_stall();
    test_flush_drain();
    test_flush_hold();
    test_bubble();
    test_reset_midwait();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
